// File: rtl/sfp_accum_dump.sv
// Integrate-and-dump accumulator for sfp samples with a one-deep output register.
// Optional macro FPLIB_ACCUM_CLIPCNT_EN adds a saturating count of clipped results.
module sfp_accum_dump #(
  parameter int IN_IW  = 2,
  parameter int IN_QW  = 6,
  parameter int OUT_IW = 4,
  parameter int OUT_QW = 6,
  parameter int N_ACC  = 16,
  parameter bit clip   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_IW+IN_QW-1:0]   in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clr,
`ifdef FPLIB_ACCUM_CLIPCNT_EN
  output logic [15:0]              clip_count,
  input  logic                     clip_count_clr,
`endif
  output logic [OUT_IW+OUT_QW-1:0] out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     clipping
);

  localparam int IW = IN_IW + IN_QW;
  localparam int OW = OUT_IW + OUT_QW;
  localparam int CW = $clog2(N_ACC);
  localparam int AW = IW + CW;
  localparam int TW = (OUT_QW >= IN_QW) ? AW + OUT_QW - IN_QW : AW - (IN_QW - OUT_QW);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] sum;
  logic signed [TW-1:0] trunc;
  logic        [CW-1:0] cnt;
  logic        [OW-1:0] res;
  logic                 ovf;
  logic                 accept;
  logic                 last;
  logic                 load;

  assign in_ext = {{CW{in[IW-1]}}, in};
  assign sum    = acc + in_ext;
  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N_ACC - 1));
  assign load   = accept && last && !clr;

  // Result register is only blocked while it holds an unaccepted result.
  assign in_ready = !(out_valid && !out_ready);

  // Fractional alignment: an arithmetic right shift truncates toward -inf.
  generate
    if (OUT_QW >= IN_QW) begin : g_qw_up
      assign trunc = TW'(sum) <<< (OUT_QW - IN_QW);
    end else begin : g_qw_down
      assign trunc = TW'(sum >>> (IN_QW - OUT_QW));
    end
  endgenerate

  // Integer resize: out of range when the dropped MSBs are not a copy of the new sign bit.
  generate
    if (TW > OW) begin : g_iw_down
      logic [TW-OW:0] hi;
      logic [OW-1:0]  sat;
      assign hi  = trunc[TW-1:OW-1];
      assign ovf = !((&hi) || !(|hi));
      assign sat = trunc[TW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      assign res = (ovf && clip) ? sat : trunc[OW-1:0];
    end else begin : g_iw_up
      assign ovf = 1'b0;
      assign res = OW'(trunc);
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= accept ? in_ext : '0;
      cnt <= accept ? CW'(1) : '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      clipping  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= res;
      clipping  <= ovf;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FPLIB_ACCUM_CLIPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clip_count_clr) begin
      clip_count <= '0;
    end else if (out_valid && out_ready && clipping && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfp_accum_dump.sv
// Bench for sfp_accum_dump: three instances (wide out, saturating narrow out,
// wrapping narrow out) share one stimulus stream; checked by table and by a frame model.
module tb_sfp_accum_dump;

  localparam int NACC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_s = '0;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic       cc_clr = 1'b0;

  logic       rdy_n, rdy_s, rdy_w;
  logic [9:0] out_n;
  logic [7:0] out_s, out_w;
  logic       ov_n, ov_s, ov_w;
  logic       clip_n, clip_s, clip_w;
`ifdef FPLIB_ACCUM_CLIPCNT_EN
  logic [15:0] cc_n, cc_s, cc_w;
`endif

  always #5 clk = ~clk;

  sfp_accum_dump #(.IN_IW(2), .IN_QW(6), .OUT_IW(4), .OUT_QW(6), .N_ACC(NACC), .clip(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .in_ready(rdy_n), .clr(clr),
`ifdef FPLIB_ACCUM_CLIPCNT_EN
    .clip_count(cc_n), .clip_count_clr(cc_clr),
`endif
    .out(out_n), .out_valid(ov_n), .out_ready(out_ready), .clipping(clip_n));

  sfp_accum_dump #(.IN_IW(2), .IN_QW(6), .OUT_IW(2), .OUT_QW(6), .N_ACC(NACC), .clip(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .in_ready(rdy_s), .clr(clr),
`ifdef FPLIB_ACCUM_CLIPCNT_EN
    .clip_count(cc_s), .clip_count_clr(cc_clr),
`endif
    .out(out_s), .out_valid(ov_s), .out_ready(out_ready), .clipping(clip_s));

  sfp_accum_dump #(.IN_IW(2), .IN_QW(6), .OUT_IW(2), .OUT_QW(6), .N_ACC(NACC), .clip(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .in_ready(rdy_w), .clr(clr),
`ifdef FPLIB_ACCUM_CLIPCNT_EN
    .clip_count(cc_w), .clip_count_clr(cc_clr),
`endif
    .out(out_w), .out_valid(ov_w), .out_ready(out_ready), .clipping(clip_w));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples of the open frame as integers in units of 2^-6,
  // plus the full-precision sum of the pending result.
  int frame[$];
  bit m_valid = 1'b0;
  int m_sum = 0;

  function automatic bit m_clip(input int sum, input int ow);
    return (sum < -(1 << (ow - 1))) || (sum > (1 << (ow - 1)) - 1);
  endfunction

  function automatic int m_out(input int sum, input int ow, input bit sat);
    int v;
    v = sum;
    if (sat && sum > (1 << (ow - 1)) - 1) v = (1 << (ow - 1)) - 1;
    if (sat && sum < -(1 << (ow - 1)))    v = -(1 << (ow - 1));
    return v & ((1 << ow) - 1);
  endfunction

  task automatic model_edge(input bit v, input logic [7:0] s, input bit c, input bit r);
    bit take, done;
    int tot;
    take = v && !(m_valid && !r);
    done = 1'b0;
    if (c) begin
      frame.delete();
      if (take) frame.push_back(int'($signed(s)));
    end else if (take) begin
      frame.push_back(int'($signed(s)));
      if (frame.size() == NACC) begin
        tot = 0;
        foreach (frame[i]) tot += frame[i];
        m_sum = tot;
        frame.delete();
        done = 1'b1;
      end
    end
    if (done) m_valid = 1'b1;
    else if (m_valid && r) m_valid = 1'b0;
  endtask

  task automatic model_check();
    bit exp_rdy;
    exp_rdy = !(m_valid && !out_ready);
    check("in_ready_n", int'(rdy_n), int'(exp_rdy));
    check("in_ready_s", int'(rdy_s), int'(exp_rdy));
    check("in_ready_w", int'(rdy_w), int'(exp_rdy));
    check("out_valid_n", int'(ov_n), int'(m_valid));
    check("out_valid_s", int'(ov_s), int'(m_valid));
    check("out_valid_w", int'(ov_w), int'(m_valid));
    if (m_valid) begin
      check("out_n", int'(out_n), m_out(m_sum, 10, 1'b1));
      check("clip_n", int'(clip_n), int'(m_clip(m_sum, 10)));
      check("out_s", int'(out_s), m_out(m_sum, 8, 1'b1));
      check("clip_s", int'(clip_s), int'(m_clip(m_sum, 8)));
      check("out_w", int'(out_w), m_out(m_sum, 8, 1'b0));
      check("clip_w", int'(clip_w), int'(m_clip(m_sum, 8)));
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic apply(input bit v, input logic [7:0] s, input bit c, input bit r);
    in_valid = v; in_s = s; clr = c; out_ready = r;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(in_valid, in_s, clr, out_ready);
    #1;
  endtask

  task automatic step(input bit v, input logic [7:0] s, input bit c, input bit r);
    apply(v, s, c, r);
    advance();
  endtask

  typedef struct {
    bit v; logic [7:0] s; bit c; bit r;
    bit e_rdy; bit e_ov;
    logic [9:0] e_n; bit e_cn;
    logic [7:0] e_s; bit e_cs;
    logic [7:0] e_w; bit e_cw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input logic [7:0] s, input bit c, input bit r,
                              input bit e_rdy, input bit e_ov,
                              input logic [9:0] e_n, input bit e_cn,
                              input logic [7:0] e_s, input bit e_cs,
                              input logic [7:0] e_w, input bit e_cw);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.r = r; t.e_rdy = e_rdy; t.e_ov = e_ov;
    t.e_n = e_n; t.e_cn = e_cn; t.e_s = e_s; t.e_cs = e_cs; t.e_w = e_w; t.e_cw = e_cw;
    return t;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1; cc_clr = 1'b0;
    rst_n = 1'b0;
    frame.delete();
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_out_valid", int'(ov_n), 0);
    check("reset_out", int'(out_n), 0);
    check("reset_clipping", int'(clip_n), 0);
    check("reset_in_ready", int'(rdy_n), 1);
    @(posedge clk);
    #1;

    // Directed frames: 1.5 x4, -0.25 x4, 1.0 x4, -2.0 x4, stall, 0.5 frame, clr cases.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'h60, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 1, 1, 10'h180, 0, 8'h7F, 1, 8'h80, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'hF0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 0, 1, 1, 1, 10'h3C0, 0, 8'hC0, 0, 8'hC0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h40, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h80, 0, 1, 1, 1, 10'h100, 0, 8'h7F, 1, 8'h00, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h80, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h20, 0, 0, 0, 1, 10'h200, 0, 8'h80, 1, 8'h00, 1));
    tbl.push_back(mk(1, 8'h20, 0, 0, 0, 1, 10'h200, 0, 8'h80, 1, 8'h00, 1));
    tbl.push_back(mk(1, 8'h20, 0, 1, 1, 1, 10'h200, 0, 8'h80, 1, 8'h00, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h20, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h20, 0, 1, 1, 1, 10'h080, 0, 8'h7F, 1, 8'h80, 1));
    tbl.push_back(mk(1, 8'h20, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h40, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 10'h100, 0, 8'h7F, 1, 8'h00, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h40, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h10, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 10'h070, 0, 8'h70, 0, 8'h70, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      apply(tbl[k].v, tbl[k].s, tbl[k].c, tbl[k].r);
      check($sformatf("tbl%0d_in_ready", k), int'(rdy_n), int'(tbl[k].e_rdy));
      check($sformatf("tbl%0d_out_valid", k), int'(ov_n), int'(tbl[k].e_ov));
      if (tbl[k].e_ov) begin
        check($sformatf("tbl%0d_out_n", k), int'(out_n), int'(tbl[k].e_n));
        check($sformatf("tbl%0d_clip_n", k), int'(clip_n), int'(tbl[k].e_cn));
        check($sformatf("tbl%0d_out_s", k), int'(out_s), int'(tbl[k].e_s));
        check($sformatf("tbl%0d_clip_s", k), int'(clip_s), int'(tbl[k].e_cs));
        check($sformatf("tbl%0d_out_w", k), int'(out_w), int'(tbl[k].e_w));
        check($sformatf("tbl%0d_clip_w", k), int'(clip_w), int'(tbl[k].e_cw));
      end
      advance();
    end

    // Reset with a pending stalled result and a partial frame behind it.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(ov_n), 0);
    check("async_rst_out", int'(out_n), 0);
    check("async_rst_clipping", int'(clip_s), 0);
    check("async_rst_in_ready", int'(rdy_n), 1);
    frame.delete();
    m_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h08, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_out_valid", int'(ov_n), 1);
    check("post_rst_sum", int'(out_n), 10'h020);
    advance();

    // Randomized traffic against the frame model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef FPLIB_ACCUM_CLIPCNT_EN
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 8'h40, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("clip_count_3", int'(cc_s), 3);
    check("clip_count_wide", int'(cc_n), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40, 1'b0, 1'b1);
    cc_clr = 1'b1;
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    check("clip_hs_before_clr", int'(ov_s && clip_s), 1);
    advance();
    cc_clr = 1'b0;
    @(negedge clk);
    check("clip_count_clr_priority", int'(cc_s), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_accum_dump.md
Name: sfp_accum_dump

Overview:
- Integrate-and-dump accumulator for sfp samples; sits directly downstream of sfp_mult / sfp_mult_ind.
- Sums N_ACC consecutive accepted input samples at full precision, then resizes the sum to the out format (clip or wrap) and presents it with a valid/ready handshake.
- Typical use: correlator/FIR-tap reduction after per-sample products.

Parameters:
- N_ACC, 16, samples per dump; integer >= 2.
- clip, 1, overflow handling on output resize: 0 = wrap, 1 = saturate.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  sfp.in  in.iw+in.qw  input sample (product from upstream multiplier).
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept the input sample.
- clr  input  1  synchronous abort: discard the partial sum and restart the frame.
- out  sfp.out  out.iw+out.qw  resized accumulated result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- clipping  output  1  result was out of range for the out format; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- sfp format: iw includes the sign bit. Representable range is [-2^(iw-1), 2^(iw-1)-2^-qw].
- Accumulator format: iw = in.iw + clog2(N_ACC), qw = in.qw, two's complement. It never overflows internally.
- Resize to out:
  - qw reduction truncates toward -inf (drops LSBs); qw increase zero-pads.
  - iw reduction: clip=1 saturates to the out min/max; clip=0 drops MSBs (wrap).
  - clipping=1 when the truncated sum lies outside the out range, for either clip setting.
- Sample counter cnt counts 0..N_ACC-1. A sample is accepted when in_valid && in_ready.
- States:
  - ACCUM: accepting samples.
  - The output register is independent of the state (skid of depth 1).
- On an accepted sample with cnt < N_ACC-1: acc += in; cnt++.
- On an accepted sample with cnt == N_ACC-1:
  - the resized (acc + in) and its clipping flag load into the output register;
  - out_valid=1 on the next cycle (latency 1 cycle from the last handshake);
  - acc=0 and cnt=0 in the same edge.
- in_ready = !(out_valid && !out_ready). A completed result is never overwritten.
  - While stalled, partial accumulation holds.
  - Back-to-back frames run at full rate if out_ready is high.
- out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- out/clipping are stable while out_valid && !out_ready.
- clr: acc=0, cnt=0; out_valid and the pending output are not affected.
  - clr together with an accepted sample: the sample becomes sample 0 of the new frame (acc=in, cnt=1).
  - clr together with the Nth sample: no dump; the sample starts the new frame.
- Reset values: out=0, out_valid=0, clipping=0, acc=0, cnt=0. in_ready=1 after reset (combinational from out_valid).
- Reset mid-frame discards the partial sum and any pending output; no glitch on out_valid after release.
- in_valid low: no state change except output handshake.

Optional Feature:
- Macro: FPLIB_ACCUM_CLIPCNT_EN.
- Defined: adds output clip_count (16 bits) and input clip_count_clr (1 bit).
  - clip_count increments on each out handshake with clipping=1 and saturates at 16'hFFFF.
  - clip_count_clr zeroes it synchronously and takes priority over an increment.
  - Reset value 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Setup for all tests: in iw=2 qw=6, N_ACC=4.
- Nominal: out iw=4 qw=6, out_ready=1; feed 1.5 ×4 back-to-back -> one cycle after the 4th handshake, out_valid=1, out=6.0 (0x180), clipping=0; next frame of -0.25 ×4 -> out=-1.0, with no bubbles on in_ready.
- Saturate: out iw=2 qw=6, clip=1; feed 1.0 ×4 -> out=1.984375 (0x7F), clipping=1. Feed -2.0 ×4 -> out=-2.0 (0x80), clipping=1.
- Wrap: same formats, clip=0; feed 1.0 ×4 -> out=0.0, clipping=1.
- Backpressure: out_ready=0 after the first dump; continue in_valid=1 -> in_ready=0 and out held constant; raise out_ready -> handshake, then the second frame completes with the correct sum.
- clr: feed 0.5 ×2, then assert clr with a sample of 1.0, then feed 1.0 ×3 -> out=4.0 (not 5.0). Assert rst_n=0 mid-frame -> all outputs 0 immediately.
- FPLIB_ACCUM_CLIPCNT_EN: 3 saturating frames -> clip_count=3; clip_count_clr together with a clipping handshake -> clip_count=0.
